// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption: 10 edges of forward key expansion, then 10 inverse rounds with the
// key schedule unwound on the fly; 20 edges from accept to done, and start is ignored while busy.
module aes_decrypt_iter (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext
);

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC} fsm_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_inv_sbox(input logic [7:0] a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  // Four S-boxes are shared: forward step feeds w3, inverse step feeds the recovered w3'.
  logic [31:0]  w0, w1, w2, w3, sb_in, sb_rot, sb_out, rc_word;
  logic [3:0]   rc_idx;
  logic [127:0] key_fwd, key_inv;
  logic [31:0]  f0, f1, f2, f3;

  assign {w0, w1, w2, w3} = key_q;
  assign sb_in   = (fsm_q == DEC) ? (w3 ^ w2) : w3;
  assign sb_rot  = {sb_in[23:0], sb_in[31:24]};
  assign rc_idx  = (fsm_q == DEC) ? rnd_q + 4'd1 : rnd_q;
  assign rc_word = {rcon(rc_idx), 24'h000000};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sb_out[8*g +: 8] = aes_sbox(sb_rot[8*g +: 8]);
  end

  assign f0      = w0 ^ sb_out ^ rc_word;
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign key_fwd = {f0, f1, f2, f3};
  assign key_inv = {w0 ^ sb_out ^ rc_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  // Byte b sits at row b%4, column b/4; InvShiftRows rotates row r right by r columns.
  logic [127:0] isr, isb, ark, imc;
  for (genvar b = 0; b < 16; b++) begin : g_inv_sbox
    localparam int Src = 4 * (((b / 4) + 4 - (b % 4)) % 4) + (b % 4);
    assign isr[127-8*b -: 8] = state_q[127-8*Src -: 8];
    assign isb[127-8*b -: 8] = aes_inv_sbox(isr[127-8*b -: 8]);
  end
  assign ark = isb ^ key_inv;
  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = data_in;
          key_d   = key;
          rnd_d   = 4'd1;
          fsm_d   = KEYEXP;
        end
      end
      KEYEXP: begin
        key_d = key_fwd;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          state_d = state_q ^ key_fwd;
          rnd_d   = 4'd9;
          fsm_d   = DEC;
        end
      end
      DEC: begin
        key_d = key_inv;
        if (rnd_q == 4'd0) begin
          pt_d   = ark;
          done_d = 1'b1;
          fsm_d  = IDLE;
        end else begin
          state_d = imc;
          rnd_d   = rnd_q - 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (fsm_q != IDLE);
  assign done      = done_q;
  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench for aes_decrypt_iter: directed known-answer vectors, back-to-back, ignored start, abort.
module tb_aes_decrypt_iter;

  logic         clk, reset, start, busy, done;
  logic [127:0] data_in, key, plaintext;

  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] K2  = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] PT2 = 128'h0123456789abcdeffedcba9876543210;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  logic         done_prev = 1'b0;
  logic [127:0] exp_q[$];
  int           acc_q[$];

  aes_decrypt_iter dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .key(key),
    .busy(busy), .done(done), .plaintext(plaintext)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check_int("done_pulse_width", int'(done_prev), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got plaintext %h with nothing outstanding", plaintext);
      end else begin
        check_vec("plaintext", plaintext, exp_q.pop_front());
        check_int("latency", cyc - acc_q.pop_front(), 20);
      end
    end
    done_prev = done;
  end

  task automatic issue(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt);
    start   = 1'b1;
    data_in = ct;
    key     = k;
    @(posedge clk);
    #1;
    exp_q.push_back(pt);
    acc_q.push_back(cyc);
    start   = 1'b0;
    data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    key     = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_done(input int bound, output int busy_cyc);
    busy_cyc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_done: got no done within %0d cycles, required one", bound);
  endtask

  int bc, d1, n0;

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    key     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_vec("reset_plaintext", plaintext, '0);
    @(negedge clk);
    reset = 1'b1;

    // FIPS-197 vector, busy length
    issue(CT1, K1, PT1);
    wait_done(40, bc);
    check_int("busy_cycles", bc, 20);
    d1 = cyc;

    // Back-to-back: start in the done cycle
    issue(CT2, K2, PT2);
    repeat (10) @(negedge clk);
    check_vec("held_plaintext", plaintext, PT1);
    check_int("busy_mid_job", int'(busy), 1);
    wait_done(40, bc);
    check_int("b2b_spacing", cyc - d1, 21);

    // start and inputs toggling while busy are ignored
    @(negedge clk);
    n0 = done_cnt;
    issue(CT1, K1, PT1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
        start   = busy;
        data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        key     = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      start = 1'b0;
      check_int("ignore_done_seen", int'(seen), 1);
    end
    repeat (3) @(negedge clk);
    check_int("ignore_no_requeue", int'(busy), 0);
    check_int("ignore_single_done", done_cnt - n0, 1);
    check_vec("ignore_result_held", plaintext, PT1);

    // Reset at E7 aborts the job
    issue(CT2, K2, PT2);
    repeat (7) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_done", int'(done), 0);
    check_vec("abort_plaintext", plaintext, '0);
    exp_q.delete();
    acc_q.delete();
    n0 = done_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check_int("abort_no_done", done_cnt - n0, 0);
    check_vec("abort_plaintext_stays", plaintext, '0);

    // Fresh job after abort
    issue(CT2, K2, PT2);
    wait_done(40, bc);
    check_int("fresh_busy_cycles", bc, 20);

    // Loopback: ciphertext as produced by the encryptor for PT2 under K2
    @(negedge clk);
    issue(CT2, K2, PT2);
    wait_done(40, bc);

    repeat (3) @(negedge clk);
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
